// File: rtl/pcs_10g_tx_block_sched_if.sv
// pcs_10g_tx_block_sched_if: encoder-side block input and scrambler-side block output
interface pcs_10g_tx_block_sched_if;
    logic [65:0] in_block;
    logic        in_valid;
    logic        in_ready;
    logic [65:0] sched_block;
    logic        sched_valid;
    modport master (output in_block, in_valid, input in_ready, sched_block, sched_valid);
    modport slave (input in_block, in_valid, output in_ready, sched_block, sched_valid);
endinterface

// File: rtl/pcs_10g_tx_block_sched.sv
// pcs_10g_tx_block_sched: gearbox-paced 66-bit block scheduler with idle insertion and drain
module pcs_10g_tx_block_sched #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          GB_PERIOD    = 33,
    parameter int          START_THRESH = 2,
    parameter logic [65:0] IDLE_BLOCK   = 66'h2_0000_0000_0000_001E,
    localparam int         AW           = $clog2(FIFO_DEPTH),
    localparam int         LW           = AW + 1,
    localparam int         SW           = $clog2(GB_PERIOD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_clear_stats,
    pcs_10g_tx_block_sched_if.slave bus,
    output logic [LW-1:0]           o_fifo_level,
    output logic [1:0]              o_state,
    output logic [31:0]             o_block_cnt,
    output logic [15:0]             o_idle_cnt,
    output logic                    o_underrun
);
    typedef enum logic [1:0] {S_DIS = 2'b00, S_PRIME = 2'b01, S_RUN = 2'b10, S_DRAIN = 2'b11} state_t;
    state_t      r_state, w_next;
    logic [SW-1:0] r_slot;
    logic [65:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [LW-1:0] r_level;
    logic [65:0] r_sched_block;
    logic        r_sched_valid;
    logic [31:0] r_block_cnt;
    logic [15:0] r_idle_cnt;
    logic        r_underrun;
    logic        w_slot, w_in_ready, w_push, w_pop, w_idle;

    assign w_slot = r_slot != SW'(GB_PERIOD - 1);

    always_ff @(posedge clk) begin
        r_state <= rst ? S_DIS : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DIS:   w_next = i_enable ? S_PRIME : S_DIS;
            S_PRIME: w_next = !i_enable ? S_DRAIN : (w_slot && r_level >= LW'(START_THRESH)) ? S_RUN : S_PRIME;
            S_RUN:   w_next = i_enable ? S_RUN : S_DRAIN;
            S_DRAIN: w_next = (w_slot && r_level == '0) ? S_DIS : S_DRAIN;
            default: w_next = S_DIS;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_PRIME || r_state == S_RUN) && r_level < LW'(FIFO_DEPTH);
        w_push     = bus.in_valid && w_in_ready;
        w_pop      = w_slot && r_level != '0 && (r_state == S_RUN || r_state == S_DRAIN);
        w_idle     = w_slot && (r_state == S_PRIME || (r_state == S_RUN && r_level == '0));
    end

    // slot counter restarts at 0 on the first PRIME cycle because it is held at 0 while disabled
    always_ff @(posedge clk) begin
        if (rst || r_state == S_DIS)
            r_slot <= '0;
        else
            r_slot <= w_slot ? r_slot + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= bus.in_block;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sched_block <= '0;
            r_sched_valid <= 1'b0;
            r_block_cnt   <= '0;
            r_idle_cnt    <= '0;
            r_underrun    <= 1'b0;
        end else begin
            r_sched_valid <= w_pop || w_idle;
            r_sched_block <= w_pop ? r_mem[r_rp] : w_idle ? IDLE_BLOCK : r_sched_block;
            r_block_cnt   <= i_clear_stats ? '0 : r_block_cnt + 32'(w_pop);
            r_idle_cnt    <= i_clear_stats ? '0 : (w_idle && r_idle_cnt != 16'hFFFF) ? r_idle_cnt + 16'd1 : r_idle_cnt;
            r_underrun    <= !i_clear_stats && (r_underrun || (w_idle && r_state == S_RUN));
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.sched_block = r_sched_block;
    assign bus.sched_valid = r_sched_valid;
    assign o_fifo_level    = r_level;
    assign o_state         = r_state;
    assign o_block_cnt     = r_block_cnt;
    assign o_idle_cnt      = r_idle_cnt;
    assign o_underrun      = r_underrun;
endmodule
